// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_pkg
//  Description : Shared types, opcodes, datapath control codes and the
//                Rx-to-register-select mapping for the micro-sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package ctrl_pkg;

  // Sequencer states; the encoding doubles as the SC debug code
  typedef enum logic [2:0] {
    ST_FETCH_L = 3'd0,
    ST_FETCH_H = 3'd1,
    ST_EXEC2   = 3'd2,
    ST_EXEC3   = 3'd3,
    ST_EXEC4   = 3'd4,
    ST_HALT    = 3'd7
  } state_t;

  // Implemented opcode subset (IR[15:10])
  localparam logic [5:0] OP_BRA = 6'h00;
  localparam logic [5:0] OP_BNE = 6'h01;
  localparam logic [5:0] OP_BEQ = 6'h02;
  localparam logic [5:0] OP_LDI = 6'h03;
  localparam logic [5:0] OP_LDA = 6'h04;
  localparam logic [5:0] OP_STA = 6'h05;
  localparam logic [5:0] OP_INC = 6'h06;
  localparam logic [5:0] OP_HLT = 6'h3F;

  // Register file function selects
  localparam logic [2:0] RF_FUN_INC   = 3'b001;
  localparam logic [2:0] RF_FUN_LOAD  = 3'b010;
  localparam logic [2:0] RF_FUN_LOADL = 3'b100;  // clear, then load low byte

  // Address register file function selects and register codes
  localparam logic [1:0] ARF_FUN_INC  = 2'b01;
  localparam logic [1:0] ARF_FUN_LOAD = 2'b10;
  localparam logic [2:0] ARF_SEL_PC   = 3'b100;
  localparam logic [2:0] ARF_SEL_AR   = 3'b010;
  localparam logic [1:0] ARF_OUTD_PC  = 2'b00;
  localparam logic [1:0] ARF_OUTD_AR  = 2'b10;

  // Data register and ALU function selects
  localparam logic [1:0] DR_FUN_LOADL  = 2'b01;
  localparam logic [4:0] ALU_FUN_PASSA = 5'b10000;

  // Mux source codes
  localparam logic [1:0] MUXA_DR  = 2'b10;   // data register into RF
  localparam logic [1:0] MUXA_IMM = 2'b11;   // IR[7:0] into RF
  localparam logic [1:0] MUXB_IMM = 2'b11;   // IR[7:0] into ARF
  localparam logic [1:0] MUXC_ALU = 2'b00;   // ALU result onto memory data bus
  localparam logic [1:0] MUXC_MEM = 2'b11;   // memory byte into DR path

  // One-hot RF write select for Rx: R1 is the MSB
  function automatic logic [3:0] rx_regsel(input logic [1:0] rx);
    logic [3:0] sel;
    case (rx)
      2'b00:   sel = 4'b1000;
      2'b01:   sel = 4'b0100;
      2'b10:   sel = 4'b0010;
      default: sel = 4'b0001;
    endcase
    return sel;
  endfunction

  // RF output-A select for Rx: R1..R4 map to codes 0..3
  function automatic logic [2:0] rx_outasel(input logic [1:0] rx);
    return {1'b0, rx};
  endfunction

  // True for every opcode the sequencer implements
  function automatic logic is_defined_op(input logic [5:0] op);
    return (op == OP_BRA) || (op == OP_BNE) || (op == OP_BEQ) ||
           (op == OP_LDI) || (op == OP_LDA) || (op == OP_STA) ||
           (op == OP_INC) || (op == OP_HLT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_output_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_output_decoder
//  Description : Combinational decode of (state, IR, Z) into every datapath
//                control output. Reset forces all outputs to idle.
//  Revision    : 1.0  initial release
// ============================================================================
module ctrl_output_decoder
  import ctrl_pkg::*;
#(
  parameter bit HALT_ON_ILLEGAL = 1'b0
) (
  input  state_t      state,
  input  logic        Reset,
  input  logic [15:0] IROut,
  input  logic        Z,
  output logic [2:0]  RF_OutASel,
  output logic [2:0]  RF_OutBSel,
  output logic [2:0]  RF_FunSel,
  output logic [3:0]  RF_RegSel,
  output logic [3:0]  RF_ScrSel,
  output logic [4:0]  ALU_FunSel,
  output logic        ALU_WF,
  output logic [1:0]  ARF_OutCSel,
  output logic [1:0]  ARF_OutDSel,
  output logic [1:0]  ARF_FunSel,
  output logic [2:0]  ARF_RegSel,
  output logic        IR_LH,
  output logic        IR_Write,
  output logic        Mem_WR,
  output logic        Mem_CS,
  output logic [1:0]  MuxASel,
  output logic [1:0]  MuxBSel,
  output logic [1:0]  MuxCSel,
  output logic        CallMode,
  output logic        MuxDSel,
  output logic        DR_E,
  output logic [1:0]  DR_FunSel,
  output logic [2:0]  SC,
  output logic        InstrDone,
  output logic        Halted
);

  logic [5:0] opcode;
  logic [1:0] rx;
  logic       take_branch;
  logic       unused_ir;

  assign opcode = IROut[15:10];
  assign rx     = IROut[9:8];
  // The address/immediate byte reaches the datapath through MuxA/MuxB directly
  assign unused_ir = ^IROut[7:0];

  // Conditional branches only gate the PC write, never the mux steering
  always_comb begin
    take_branch = 1'b0;
    case (opcode)
      OP_BRA:  take_branch = 1'b1;
      OP_BNE:  take_branch = ~Z;
      OP_BEQ:  take_branch = Z;
      default: take_branch = 1'b0;
    endcase
  end

  // Moore control outputs; everything idles first, then the state adds enables
  always_comb begin
    RF_OutASel  = 3'b000;
    RF_OutBSel  = 3'b000;
    RF_FunSel   = 3'b000;
    RF_RegSel   = 4'b0000;
    RF_ScrSel   = 4'b0000;
    ALU_FunSel  = 5'b00000;
    ALU_WF      = 1'b0;
    ARF_OutCSel = 2'b00;
    ARF_OutDSel = 2'b00;
    ARF_FunSel  = 2'b00;
    ARF_RegSel  = 3'b000;
    IR_LH       = 1'b0;
    IR_Write    = 1'b0;
    Mem_WR      = 1'b0;
    Mem_CS      = 1'b1;
    MuxASel     = 2'b00;
    MuxBSel     = 2'b00;
    MuxCSel     = 2'b00;
    CallMode    = 1'b0;
    MuxDSel     = 1'b0;
    DR_E        = 1'b0;
    DR_FunSel   = 2'b00;
    SC          = 3'b000;
    InstrDone   = 1'b0;
    Halted      = 1'b0;

    if (!Reset) begin
      SC = state;
      case (state)
        ST_FETCH_L, ST_FETCH_H: begin
          // Read the byte at PC into the selected IR half and bump PC
          ARF_OutDSel = ARF_OUTD_PC;
          Mem_CS      = 1'b0;
          IR_Write    = 1'b1;
          IR_LH       = (state == ST_FETCH_H);
          ARF_RegSel  = ARF_SEL_PC;
          ARF_FunSel  = ARF_FUN_INC;
        end

        ST_EXEC2: begin
          case (opcode)
            OP_BRA, OP_BNE, OP_BEQ: begin
              MuxBSel   = MUXB_IMM;
              InstrDone = 1'b1;
              if (take_branch) begin
                ARF_RegSel = ARF_SEL_PC;
                ARF_FunSel = ARF_FUN_LOAD;
              end
            end
            OP_LDI: begin
              MuxASel   = MUXA_IMM;
              RF_FunSel = RF_FUN_LOADL;
              RF_RegSel = rx_regsel(rx);
              InstrDone = 1'b1;
            end
            OP_INC: begin
              RF_FunSel = RF_FUN_INC;
              RF_RegSel = rx_regsel(rx);
              InstrDone = 1'b1;
            end
            OP_LDA, OP_STA: begin
              // Latch the direct address into AR for the memory cycle
              MuxBSel    = MUXB_IMM;
              ARF_RegSel = ARF_SEL_AR;
              ARF_FunSel = ARF_FUN_LOAD;
            end
            OP_HLT: begin
              InstrDone = 1'b0;
            end
            default: begin
              InstrDone = ~HALT_ON_ILLEGAL;
            end
          endcase
        end

        ST_EXEC3: begin
          if (opcode == OP_LDA) begin
            ARF_OutDSel = ARF_OUTD_AR;
            Mem_CS      = 1'b0;
            MuxCSel     = MUXC_MEM;
            DR_E        = 1'b1;
            DR_FunSel   = DR_FUN_LOADL;
          end else if (opcode == OP_STA) begin
            RF_OutASel  = rx_outasel(rx);
            ALU_FunSel  = ALU_FUN_PASSA;
            MuxCSel     = MUXC_ALU;
            ARF_OutDSel = ARF_OUTD_AR;
            Mem_CS      = 1'b0;
            Mem_WR      = 1'b1;
            InstrDone   = 1'b1;
          end
        end

        ST_EXEC4: begin
          // Only LDA reaches here: move DR into Rx
          MuxASel   = MUXA_DR;
          RF_FunSel = RF_FUN_LOAD;
          RF_RegSel = rx_regsel(rx);
          InstrDone = 1'b1;
        end

        ST_HALT: begin
          Halted = 1'b1;
        end

        default: begin
          SC = state;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/control_unit_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : control_unit_sequencer
//  Description : Hardwired micro-sequencer: two-byte fetch into IR, decode and
//                multi-cycle execute of an 8-opcode subset. Holds the state
//                register and next-state logic; outputs come from the decoder.
//  Revision    : 1.0  initial release
// ============================================================================
module control_unit_sequencer
  import ctrl_pkg::*;
#(
  parameter bit HALT_ON_ILLEGAL = 1'b0
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] IROut,
  input  logic        Z,
  output logic [2:0]  RF_OutASel,
  output logic [2:0]  RF_OutBSel,
  output logic [2:0]  RF_FunSel,
  output logic [3:0]  RF_RegSel,
  output logic [3:0]  RF_ScrSel,
  output logic [4:0]  ALU_FunSel,
  output logic        ALU_WF,
  output logic [1:0]  ARF_OutCSel,
  output logic [1:0]  ARF_OutDSel,
  output logic [1:0]  ARF_FunSel,
  output logic [2:0]  ARF_RegSel,
  output logic        IR_LH,
  output logic        IR_Write,
  output logic        Mem_WR,
  output logic        Mem_CS,
  output logic [1:0]  MuxASel,
  output logic [1:0]  MuxBSel,
  output logic [1:0]  MuxCSel,
  output logic        CallMode,
  output logic        MuxDSel,
  output logic        DR_E,
  output logic [1:0]  DR_FunSel,
  output logic [2:0]  SC,
  output logic        InstrDone,
  output logic        Halted
);

  state_t     r_state;
  logic [5:0] opcode;
  logic       unused_ir;

  assign opcode    = IROut[15:10];
  assign unused_ir = ^IROut[9:0];

  // State register with next-state selection; HALT is left only through Reset
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= ST_FETCH_L;
    end else begin
      case (r_state)
        ST_FETCH_L: r_state <= ST_FETCH_H;
        ST_FETCH_H: r_state <= ST_EXEC2;
        ST_EXEC2: begin
          if ((opcode == OP_LDA) || (opcode == OP_STA)) begin
            r_state <= ST_EXEC3;
          end else if (opcode == OP_HLT) begin
            r_state <= ST_HALT;
          end else if (HALT_ON_ILLEGAL && !is_defined_op(opcode)) begin
            r_state <= ST_HALT;
          end else begin
            r_state <= ST_FETCH_L;
          end
        end
        ST_EXEC3:   r_state <= (opcode == OP_LDA) ? ST_EXEC4 : ST_FETCH_L;
        ST_EXEC4:   r_state <= ST_FETCH_L;
        ST_HALT:    r_state <= ST_HALT;
        default:    r_state <= ST_FETCH_L;
      endcase
    end
  end

  ctrl_output_decoder #(
    .HALT_ON_ILLEGAL (HALT_ON_ILLEGAL)
  ) u_decoder (
    .state       (r_state),
    .Reset       (Reset),
    .IROut       (IROut),
    .Z           (Z),
    .RF_OutASel  (RF_OutASel),
    .RF_OutBSel  (RF_OutBSel),
    .RF_FunSel   (RF_FunSel),
    .RF_RegSel   (RF_RegSel),
    .RF_ScrSel   (RF_ScrSel),
    .ALU_FunSel  (ALU_FunSel),
    .ALU_WF      (ALU_WF),
    .ARF_OutCSel (ARF_OutCSel),
    .ARF_OutDSel (ARF_OutDSel),
    .ARF_FunSel  (ARF_FunSel),
    .ARF_RegSel  (ARF_RegSel),
    .IR_LH       (IR_LH),
    .IR_Write    (IR_Write),
    .Mem_WR      (Mem_WR),
    .Mem_CS      (Mem_CS),
    .MuxASel     (MuxASel),
    .MuxBSel     (MuxBSel),
    .MuxCSel     (MuxCSel),
    .CallMode    (CallMode),
    .MuxDSel     (MuxDSel),
    .DR_E        (DR_E),
    .DR_FunSel   (DR_FunSel),
    .SC          (SC),
    .InstrDone   (InstrDone),
    .Halted      (Halted)
  );

endmodule
`default_nettype wire

// File: doc/control_unit_sequencer.md
Name: control_unit_sequencer

Overview:
Hardwired micro-sequencer that drives every control input of the ALU-system datapath (RF, ALU, ARF, IR, DR, Memory, Muxes A–D). It fetches a 16-bit instruction as two memory bytes into the IR, decodes it, and runs a multi-cycle execute sequence. It implements an 8-opcode subset (branches, register load/store, increment, halt). It sits beside the datapath in the CPU top level and receives only IROut and the ALU Z flag back.

Parameters:
HALT_ON_ILLEGAL, 0, 1: an undefined opcode enters HALT; 0: an undefined opcode executes as a 3-cycle NOP.

Ports:
Clock  in  1  system clock; all state updates on the rising edge
Reset  in  1  synchronous, active-high; forces state FETCH_L and idle outputs
IROut  in  16  IR contents: [15:10] opcode, [9:8] Rx, [7:0] address/immediate
Z  in  1  ALU zero flag (FlagsOut Z bit)
RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, RF_ScrSel  out  3,3,3,4,4  RF controls
ALU_FunSel, ALU_WF  out  5,1  ALU controls
ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel  out  2,2,2,3  ARF controls
IR_LH, IR_Write, Mem_WR, Mem_CS  out  1 each  IR and memory controls
MuxASel, MuxBSel, MuxCSel, CallMode, MuxDSel  out  2,2,2,1,1  mux controls
DR_E, DR_FunSel  out  1,2  DR controls
SC  out  3  current state code (debug)
InstrDone  out  1  one-cycle pulse in the last execute cycle of each instruction
Halted  out  1  high while in HALT

Behaviour:
- Outputs are Moore: combinational from registered state and IROut. No output depends on Z except ARF_RegSel/ARF_FunSel in T2 of BEQ/BNE.
- Idle/default values (also forced while Reset=1):
  - RF_RegSel=4'b0000, RF_ScrSel=4'b0000, ARF_RegSel=3'b000
  - IR_Write=0, DR_E=0, Mem_CS=1 (active-low, disabled), Mem_WR=0
  - ALU_WF=0, CallMode=0, MuxDSel=0
  - All select and FunSel outputs = 0
  - InstrDone=0, Halted=0
- States, with SC encoding: FETCH_L=0, FETCH_H=1, EXEC2=2, EXEC3=3, EXEC4=4, HALT=7.
- FETCH_L:
  - ARF_OutDSel=PC(2'b00), Mem_CS=0, Mem_WR=0
  - IR_Write=1, IR_LH=0
  - ARF_RegSel=PC(3'b100), ARF_FunSel=INC(2'b01)
  - Next state: FETCH_H
- FETCH_H: same as FETCH_L but IR_LH=1. Next state: EXEC2.
- Rx mapping: IR[9:8] 00→R1, 01→R2, 10→R3, 11→R4.
  - RF_RegSel one-hot: 1000, 0100, 0010, 0001
  - RF_OutASel: 000, 001, 010, 011
- EXEC2, by opcode:
  - 0x00 BRA: MuxBSel=11, ARF_RegSel=PC, ARF_FunSel=LOAD(2'b10). Done.
  - 0x01 BNE: same as BRA only if Z=0, else no write. Done.
  - 0x02 BEQ: same as BRA only if Z=1, else no write. Done.
  - 0x03 LDI: MuxASel=11, RF_FunSel=LOADL(3'b100, clear+load low), RF_RegSel=Rx. Done.
  - 0x06 INC: RF_FunSel=INC(3'b001), RF_RegSel=Rx. Done.
  - 0x04 LDA / 0x05 STA: MuxBSel=11, ARF_RegSel=AR(3'b010), ARF_FunSel=LOAD. Next state: EXEC3.
  - 0x3F HLT: next state HALT, no writes.
  - Other opcodes: NOP (Done), or HALT if HALT_ON_ILLEGAL=1.
- EXEC3:
  - LDA: ARF_OutDSel=AR(2'b10), Mem_CS=0, Mem_WR=0, MuxCSel=11, DR_E=1, DR_FunSel=LOADL(2'b01). Next state: EXEC4.
  - STA: RF_OutASel=Rx, ALU_FunSel=PASSA(5'b10000), MuxCSel=00, ARF_OutDSel=AR, Mem_CS=0, Mem_WR=1. Done.
- EXEC4 (LDA only): MuxASel=10, RF_FunSel=LOAD(3'b010), RF_RegSel=Rx. Done.
- "Done" means: InstrDone=1 and next state is FETCH_L.
- Latency in cycles: BRA/BNE/BEQ/LDI/INC/NOP = 3, STA = 4, LDA = 5.
- A branch load in EXEC2 overrides the two prior PC increments. The target is {8'h00, IR[7:0]}.
- HALT: all outputs idle, Halted=1. The only exit is Reset.
- Reset asserted in any state, including mid-LDA/STA: next state FETCH_L, no memory write that cycle, partial results abandoned.
- ALU_WF stays 0 in every state; flags are preserved across this subset.

Decomposition:
- Package ctrl_pkg contains:
  - state enum and SC codes
  - opcode constants
  - RF/ARF/DR/ALU FunSel constants
  - ARF RegSel/OutDSel codes
  - Rx-to-RegSel/OutASel mapping function
- One natural sub-module: ctrl_output_decoder, combinational (state, IROut, Z) → all control outputs. The top module holds only the state register and next-state logic.

Test Plan:
- Reset held 2 cycles, then released:
  - Required: SC=0, Mem_CS=0, IR_Write=1, IR_LH=0, ARF_FunSel=01 in the first cycle.
  - Required: SC=1 with IR_LH=1 in the second cycle.
- LDI: IROut=16'h0E5A (opcode 0x03, Rx=R3):
  - Required in EXEC2: RF_RegSel=0010, RF_FunSel=100, MuxASel=11, InstrDone=1.
  - Required: SC returns to 0.
- BEQ: IROut=16'h0840 with Z=0 → ARF_RegSel=000 in EXEC2. Repeat with Z=1 → ARF_RegSel=100, ARF_FunSel=10, MuxBSel=11.
- LDA: IROut=16'h1120 (Rx=R2):
  - Required sequence: SC 0,1,2,3,4.
  - Required in EXEC3: DR_E=1, MuxCSel=11, ARF_OutDSel=10.
  - Required in EXEC4: RF_RegSel=0100, RF_FunSel=010.
  - Required: InstrDone only in EXEC4.
- STA: IROut=16'h1730 (Rx=R4):
  - Required in EXEC3: Mem_WR=1, Mem_CS=0, RF_OutASel=011, ALU_FunSel=10000.
  - Then: Reset pulsed during EXEC3 of a second STA → next cycle SC=0, Mem_WR=0.
- HLT: IROut=16'hFC00 → SC=7, Halted=1 held for 20 cycles with all enables idle; Reset → SC=0. Repeat with opcode 0x2A under HALT_ON_ILLEGAL=0 (NOP, 3 cycles) and HALT_ON_ILLEGAL=1 (HALT).
